// File: rtl/eeprom_ctrl.sv
// Erase/program/read sequencing controller for a 16x16 EEPROM array.
// Optional read-back verify after program/erase: define EEPROM_CTRL_VERIFY_EN.
module eeprom_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16,
  parameter int ERASE_CYCLES = 4,
  parameter int PROG_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_erase,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int MAX_CYCLES = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    PROG,
    READ,
    DONE
`ifdef EEPROM_CTRL_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t            state_r;
  state_t            state_next;
  state_t            after_write_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        op_r;
  logic [DATA_W-1:0] wdata_r;

`ifdef EEPROM_CTRL_VERIFY_EN
  logic [DATA_W-1:0] expect_s;
  assign after_write_s = VERIFY;
  assign expect_s      = (op_r == OP_ERASE) ? {DATA_W{1'b0}} : wdata_r;
`else
  assign after_write_s = DONE;
  assign resp_err      = 1'b0;
`endif

  // Next-state decode; req_ready is high exactly in IDLE, so req_valid alone accepts there.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_READ:  state_next = READ;
            OP_WRITE: state_next = ERASE;
            OP_ERASE: state_next = ERASE;
            default:  state_next = DONE;
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      ERASE: begin
        if (cnt_r == ERASE_LAST) begin
          if (op_r == OP_WRITE) begin
            state_next = PROG;
          end else begin
            state_next = after_write_s;
          end
        end else begin
          state_next = ERASE;
        end
      end
      PROG: begin
        if (cnt_r == PROG_LAST) begin
          state_next = after_write_s;
        end else begin
          state_next = PROG;
        end
      end
      READ:    state_next = DONE;
`ifdef EEPROM_CTRL_VERIFY_EN
      VERIFY:  state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, phase counter, request latch and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_r       <= 2'b00;
      wdata_r    <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_erase  <= 1'b0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
`ifdef EEPROM_CTRL_VERIFY_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      state_r <= state_next;
      // Counter restarts on every phase change and saturates rather than wrapping.
      if (state_next != state_r) begin
        cnt_r <= '0;
      end else if (cnt_r != '1) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (state_r == IDLE && req_valid) begin
        op_r     <= req_op;
        mem_addr <= req_addr;
        wdata_r  <= req_wdata;
      end
      req_ready  <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
      resp_valid <= (state_next == DONE);
      mem_erase  <= (state_next == ERASE);
      mem_we     <= (state_next == PROG);
      mem_din    <= (state_next == PROG) ? wdata_r : {DATA_W{1'b0}};
      if (state_r == READ) begin
        resp_rdata <= mem_dout;
      end
`ifdef EEPROM_CTRL_VERIFY_EN
      if (state_r == VERIFY) begin
        resp_rdata <= mem_dout;
        resp_err   <= (mem_dout != expect_s);
      end
`endif
    end
  end

endmodule
